id_ex_issue: RTL and testbench

- ID/EX pipeline register plus operand-forwarding network directly upstream of the execute-stage ALU.
- Captures decoded instructions and resolves RAW hazards by bypassing from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU's OP/In1/In2 inputs, and carries destination/control fields to EX/MEM.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/id_ex_issue_fwd_mux.sv | 32 +++
 rtl/id_ex_issue.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_issue.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-style execute stage: ALU opcodes, operand
// select values and the control bundle carried from ID to EX.
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1011;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_SGT = 4'b1110;
    localparam logic [3:0] ALU_SEQ = 4'b1111;

    // 11 is reserved and decodes like the register/register form.
    localparam logic [1:0] ALU_SRC_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
    localparam logic [1:0] ALU_SRC_SHIFT = 2'b10;
    localparam logic [1:0] ALU_SRC_RSVD  = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_op:    ALU_ADD,
        alu_src:   ALU_SRC_REG
    };

endpackage

// File: rtl/id_ex_issue_fwd_mux.sv
// One execute-time bypass selector: EX/MEM beats MEM/WB, which beats the
// value captured at issue. Register 0 is never bypassed.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic [RA_W-1:0]   idx,
    input  logic [DATA_W-1:0] captured,
    input  logic              mem_reg_write,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == idx);
        wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == idx);
        fwd     = captured;
        if (mem_hit) begin
            fwd = mem_result;
        end else if (wb_hit) begin
            fwd = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register: captures decoded instructions, inserts bubbles on
// load-use hazards or flush, and forwards operands into the ALU.
module id_ex_issue
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_op,
    input  logic [1:0]        id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              ex_valid,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [DATA_W-1:0] ex_store_data
);

    logic              valid_q, valid_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [RA_W-1:0]   rs_idx_q, rs_idx_d;
    logic [RA_W-1:0]   rt_idx_q, rt_idx_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d;
    logic [DATA_W-1:0] rt_val_q, rt_val_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        shamt_q, shamt_d;
    ex_ctrl_t          ctrl_q, ctrl_d;

    logic              load_use;
    logic              wb_byp_rs, wb_byp_rt;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    always_comb begin
        load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                   ((id_uses_rs && (id_rs == rd_q)) || (id_uses_rt && (id_rt == rd_q)));
        stall     = ex_hold || (load_use && !flush);
        wb_byp_rs = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs);
        wb_byp_rt = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt);

        valid_d  = valid_q;
        rd_d     = rd_q;
        rs_idx_d = rs_idx_q;
        rt_idx_d = rt_idx_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        imm_d    = imm_q;
        shamt_d  = shamt_q;
        ctrl_d   = ctrl_q;

        // A bubble also zeroes the source indices so nothing gets bypassed into it.
        if (!ex_hold) begin
            if (flush || load_use) begin
                valid_d  = 1'b0;
                rd_d     = '0;
                rs_idx_d = '0;
                rt_idx_d = '0;
                rs_val_d = '0;
                rt_val_d = '0;
                imm_d    = '0;
                shamt_d  = '0;
                ctrl_d   = CTRL_BUBBLE;
            end else begin
                valid_d          = id_valid;
                rd_d             = id_rd;
                rs_idx_d         = id_rs;
                rt_idx_d         = id_rt;
                rs_val_d         = wb_byp_rs ? wb_data : id_rs_data;
                rt_val_d         = wb_byp_rt ? wb_data : id_rt_data;
                imm_d            = id_imm;
                shamt_d          = id_shamt;
                ctrl_d.reg_write = id_reg_write && id_valid;
                ctrl_d.mem_read  = id_mem_read && id_valid;
                ctrl_d.mem_write = id_mem_write && id_valid;
                ctrl_d.alu_op    = id_alu_op;
                ctrl_d.alu_src   = id_alu_src;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rd_q     <= '0;
            rs_idx_q <= '0;
            rt_idx_q <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            shamt_q  <= '0;
            ctrl_q   <= CTRL_BUBBLE;
        end else begin
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            rs_idx_q <= rs_idx_d;
            rt_idx_q <= rt_idx_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
            shamt_q  <= shamt_d;
            ctrl_q   <= ctrl_d;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
        .idx           (rs_idx_q),
        .captured      (rs_val_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd           (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
        .idx           (rt_idx_q),
        .captured      (rt_val_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd           (rt_fwd)
    );

    // Shifts take the value from rt and the amount from the instruction field.
    always_comb begin
        alu_in1 = rs_fwd;
        alu_in2 = rt_fwd;
        case (ctrl_q.alu_src)
            ALU_SRC_IMM: begin
                alu_in2 = imm_q;
            end
            ALU_SRC_SHIFT: begin
                alu_in1 = rt_fwd;
                alu_in2 = {{(DATA_W-5){1'b0}}, shamt_q};
            end
            default: begin
                alu_in1 = rs_fwd;
                alu_in2 = rt_fwd;
            end
        endcase
    end

    assign alu_op        = ctrl_q.alu_op;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: a vector table for single-issue cases plus
// hand-written sequences for load-use, hold, flush and asynchronous reset.
module tb_id_ex_issue;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_alu_src;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        ex_hold, flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1, alu_in2;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_store_data;

    int pass_count;
    int check_count;

    typedef struct {
        logic        vld;
        logic [4:0]  rs, rt, rd;
        logic        urs, urt;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh;
        logic [3:0]  op;
        logic [1:0]  src;
        logic        rw, mr, mw;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        e_vld;
        logic [4:0]  e_rd;
        logic        e_rw, e_mr, e_mw;
        logic [3:0]  e_op;
        logic [31:0] e_in1, e_in2, e_st;
    } vec_t;

    vec_t vecs[11];
    vec_t idle;
    vec_t v;

    id_ex_issue #(.DATA_W(32), .RA_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_shamt      (id_shamt),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .stall         (stall),
        .alu_op        (alu_op),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_store_data (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t s);
        id_valid      = s.vld;
        id_rs         = s.rs;
        id_rt         = s.rt;
        id_rd         = s.rd;
        id_uses_rs    = s.urs;
        id_uses_rt    = s.urt;
        id_rs_data    = s.rsd;
        id_rt_data    = s.rtd;
        id_imm        = s.imm;
        id_shamt      = s.sh;
        id_alu_op     = s.op;
        id_alu_src    = s.src;
        id_reg_write  = s.rw;
        id_mem_read   = s.mr;
        id_mem_write  = s.mw;
        mem_reg_write = s.mrw;
        mem_rd        = s.mrd;
        mem_result    = s.mres;
        wb_reg_write  = s.wrw;
        wb_rd         = s.wrd;
        wb_data       = s.wdat;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic checkAll(input string tag, input logic e_vld, input logic [4:0] e_rd,
                            input logic e_rw, input logic e_mr, input logic e_mw,
                            input logic [3:0] e_op, input logic [31:0] e_in1,
                            input logic [31:0] e_in2, input logic [31:0] e_st);
        checkOutput({tag, ".ex_valid"}, 32'(ex_valid), 32'(e_vld));
        checkOutput({tag, ".ex_rd"}, 32'(ex_rd), 32'(e_rd));
        checkOutput({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(e_rw));
        checkOutput({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(e_mr));
        checkOutput({tag, ".ex_mem_write"}, 32'(ex_mem_write), 32'(e_mw));
        checkOutput({tag, ".alu_op"}, 32'(alu_op), 32'(e_op));
        checkOutput({tag, ".alu_in1"}, alu_in1, e_in1);
        checkOutput({tag, ".alu_in2"}, alu_in2, e_in2);
        checkOutput({tag, ".store_data"}, ex_store_data, e_st);
    endtask

    task automatic checkStall(input string tag, input logic e_stall);
        checkOutput({tag, ".stall"}, 32'(stall), 32'(e_stall));
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;

        idle = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, ALU_ADD, ALU_SRC_REG, 1'b0, 1'b0, 1'b0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0};

        // add r3,r1,r2
        vecs[0]  = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, 5'd0, ALU_ADD, ALU_SRC_REG, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 5'd3, 1'b1, 1'b0, 1'b0, ALU_ADD, 32'h11, 32'h22, 32'h22};
        // addi r9,r4,-16
        vecs[1]  = '{1'b1, 5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 32'h100, 32'h5, 32'hFFFF_FFF0, 5'd0, ALU_ADD, ALU_SRC_IMM, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 5'd9, 1'b1, 1'b0, 1'b0, ALU_ADD, 32'h100, 32'hFFFF_FFF0, 32'h5};
        // sub r4,r3,r2 with r3 bypassed from EX/MEM
        vecs[2]  = '{1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b1, 32'h99, 32'h5, 32'h0, 5'd0, ALU_SUB, ALU_SRC_REG, 1'b1, 1'b0, 1'b0,
                     1'b1, 5'd3, 32'h10, 1'b0, 5'd0, 32'h0,
                     1'b1, 5'd4, 1'b1, 1'b0, 1'b0, ALU_SUB, 32'h10, 32'h5, 32'h5};
        // EX/MEM and MEM/WB both write r7: EX/MEM wins
        vecs[3]  = '{1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 32'h77, 32'h1, 32'h0, 5'd0, ALU_AND, ALU_SRC_REG, 1'b1, 1'b0, 1'b0,
                     1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB,
                     1'b1, 5'd8, 1'b1, 1'b0, 1'b0, ALU_AND, 32'hA, 32'h1, 32'h1};
        // same with r0: never forwarded
        vecs[4]  = '{1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, ALU_OR, ALU_SRC_REG, 1'b1, 1'b0, 1'b0,
                     1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hB,
                     1'b1, 5'd2, 1'b1, 1'b0, 1'b0, ALU_OR, 32'h0, 32'h0, 32'h0};
        // rt bypassed from MEM/WB
        vecs[5]  = '{1'b1, 5'd2, 5'd6, 5'd10, 1'b1, 1'b1, 32'h3, 32'h44, 32'h0, 5'd0, ALU_ADD, ALU_SRC_REG, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66,
                     1'b1, 5'd10, 1'b1, 1'b0, 1'b0, ALU_ADD, 32'h3, 32'h66, 32'h66};
        // sll r5,r3,4
        vecs[6]  = '{1'b1, 5'd0, 5'd3, 5'd5, 1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 5'd4, ALU_SLL, ALU_SRC_SHIFT, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 5'd5, 1'b1, 1'b0, 1'b0, ALU_SLL, 32'h1, 32'h4, 32'h1};
        // reserved operand select acts as register/register
        vecs[7]  = '{1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 32'h5, 32'h6, 32'h123, 5'd0, ALU_XOR, ALU_SRC_RSVD, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 5'd11, 1'b1, 1'b0, 1'b0, ALU_XOR, 32'h5, 32'h6, 32'h6};
        // sw r9,4(r8)
        vecs[8]  = '{1'b1, 5'd8, 5'd9, 5'd0, 1'b1, 1'b1, 32'h1000, 32'hDEAD, 32'h4, 5'd0, ALU_ADD, ALU_SRC_IMM, 1'b0, 1'b0, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 5'd0, 1'b0, 1'b0, 1'b1, ALU_ADD, 32'h1000, 32'h4, 32'hDEAD};
        // matching indices but no write enables: no bypass
        vecs[9]  = '{1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1, 32'h33, 32'h44, 32'h0, 5'd0, ALU_NOR, ALU_SRC_REG, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd3, 32'hBAD, 1'b0, 5'd4, 32'hBEE,
                     1'b1, 5'd12, 1'b1, 1'b0, 1'b0, ALU_NOR, 32'h33, 32'h44, 32'h44};
        // empty decode slot
        vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, ALU_ADD, ALU_SRC_REG, 1'b0, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0};

        rst_n   = 1'b0;
        ex_hold = 1'b0;
        flush   = 1'b0;
        applyStimulus(idle);
        #2;
        checkAll("reset", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0);
        checkStall("reset", 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkStall($sformatf("vec%0d", i), 1'b0);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_mr,
                     vecs[i].e_mw, vecs[i].e_op, vecs[i].e_in1, vecs[i].e_in2, vecs[i].e_st);
        end

        // Load-use: lw r5 then or r6,r5,r1 -> one bubble, then issue with r5 from MEM/WB
        v = idle;
        v.vld = 1'b1; v.rs = 5'd1; v.rt = 5'd5; v.rd = 5'd5; v.urs = 1'b1;
        v.rsd = 32'h200; v.imm = 32'h8; v.src = ALU_SRC_IMM; v.rw = 1'b1; v.mr = 1'b1;
        applyStimulus(v);
        tick();
        checkAll("lw", 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, ALU_ADD, 32'h200, 32'h8, 32'h0);
        v = idle;
        v.vld = 1'b1; v.rs = 5'd5; v.rt = 5'd1; v.rd = 5'd6; v.urs = 1'b1; v.urt = 1'b1;
        v.rsd = 32'h0; v.rtd = 32'h7; v.op = ALU_OR; v.rw = 1'b1;
        applyStimulus(v);
        #1;
        checkStall("lu_detect", 1'b1);
        tick();
        checkAll("lu_bubble", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0);
        checkStall("lu_release", 1'b0);
        tick();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE;
        #1;
        checkAll("lu_issue", 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, ALU_OR, 32'hCAFE, 32'h7, 32'h7);
        checkStall("lu_issue", 1'b0);

        // Shift then a 3-cycle hold; flush raised mid-hold must wait for the hold to drop
        applyStimulus(vecs[6]);
        tick();
        checkAll("sll", 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, ALU_SLL, 32'h1, 32'h4, 32'h1);
        v = idle;
        v.vld = 1'b1; v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd9; v.urs = 1'b1; v.urt = 1'b1;
        v.rsd = 32'hAA; v.rtd = 32'hBB; v.op = ALU_SUB; v.rw = 1'b1;
        applyStimulus(v);
        ex_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c >= 1);
            #1;
            checkStall($sformatf("hold%0d", c), 1'b1);
            tick();
            checkAll($sformatf("hold%0d", c), 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, ALU_SLL, 32'h1, 32'h4, 32'h1);
        end
        ex_hold = 1'b0;
        #1;
        checkStall("hold_drop", 1'b0);
        tick();
        checkAll("flush_after_hold", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0);
        flush = 1'b0;

        // Flush overrides load-use: no stall, bubble loaded
        v = idle;
        v.vld = 1'b1; v.rs = 5'd1; v.rt = 5'd5; v.rd = 5'd5; v.urs = 1'b1;
        v.rsd = 32'h300; v.imm = 32'h4; v.src = ALU_SRC_IMM; v.rw = 1'b1; v.mr = 1'b1;
        applyStimulus(v);
        tick();
        v = idle;
        v.vld = 1'b1; v.rs = 5'd5; v.rt = 5'd1; v.rd = 5'd6; v.urs = 1'b1; v.urt = 1'b1;
        v.rtd = 32'h7; v.op = ALU_OR; v.rw = 1'b1;
        applyStimulus(v);
        flush = 1'b1;
        #1;
        checkStall("flush_lu", 1'b0);
        tick();
        checkAll("flush_lu", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0);
        flush = 1'b0;

        // Capture-time bypass keeps the MEM/WB value after the producer retires
        v = idle;
        v.vld = 1'b1; v.rs = 5'd12; v.rt = 5'd13; v.rd = 5'd14; v.urs = 1'b1; v.urt = 1'b1;
        v.rsd = 32'h1; v.rtd = 32'h2; v.rw = 1'b1;
        v.wrw = 1'b1; v.wrd = 5'd12; v.wdat = 32'h55;
        applyStimulus(v);
        tick();
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        #1;
        checkAll("cap_bypass", 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, ALU_ADD, 32'h55, 32'h2, 32'h2);

        // Asynchronous reset between edges, then reload on the next edge
        applyStimulus(vecs[0]);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("rst_mid", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0);
        checkStall("rst_mid", 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release.ex_valid", 32'(ex_valid), 32'h0);
        tick();
        checkAll("rst_reload", 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, ALU_ADD, 32'h11, 32'h22, 32'h22);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
